processador_pio_in: RTL and testbench

Avalon-MM slave input port: the CPU-read counterpart of the 12-bit output PIO on the processor bus. Samples an external bus through a synchronizer, exposes its current value, latches selected edges into a sticky capture register, and raises a maskable level interrupt to the Nios core. Coprocessor status lines (done, busy, error flags) return to software through this block.

---
 rtl/processador_pio_pkg.sv | 19 +
 rtl/processador_pio_in_sync_edge.sv | 46 ++++
 rtl/processador_pio_in.sv | 95 +++++++++
 tb/tb_processador_pio_in.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/processador_pio_pkg.sv
// processador_pio_pkg: shared definitions for the processor-bus PIO blocks.
//   pio_addr_e : Avalon-MM word addresses of the PIO register map.
//   pio_edge_e : encodings for the EDGE_TYPE parameter of the input PIO.
package processador_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  typedef enum int {
    EDGE_RISING  = 0,
    EDGE_FALLING = 1,
    EDGE_ANY     = 2
  } pio_edge_e;

endpackage

// File: rtl/processador_pio_in_sync_edge.sv
// pio_sync_edge: multi-flop synchronizer for the external input bus, a
// one-cycle history register, and per-bit edge detection.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_in             : asynchronous external inputs
//   o_sync           : synchronized inputs
//   o_edge           : per-bit edge strobe of the kind chosen by EDGE_TYPE
module pio_sync_edge
  import processador_pio_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    o_edge = '0;
    case (EDGE_TYPE)
      int'(EDGE_RISING):  o_edge = o_sync & ~r_prev;
      int'(EDGE_FALLING): o_edge = ~o_sync & r_prev;
      default:            o_edge = o_sync ^ r_prev;
    endcase
  end

endmodule

// File: rtl/processador_pio_in.sv
// processador_pio_in: Avalon-MM slave input PIO. Reports the synchronized
// input bus, latches selected edges into sticky flags, and raises a maskable
// level interrupt.
//   clk, reset_n        : bus clock, asynchronous active-low reset
//   address, chipselect : word address (0 DATA, 1 rsvd, 2 IRQMASK, 3 EDGECAP)
//   write_n, writedata  : active-low write strobe and data (upper bits unused)
//   in_port             : asynchronous external inputs
//   readdata            : registered, zero-extended read data (latency 1)
//   irq                 : level interrupt, |(EDGECAP & IRQMASK)
module processador_pio_in
  import processador_pio_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Capture stays disabled until the synchronizer and history register have
  // both seen post-reset input, so a line already high at release is not
  // mistaken for an edge.
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] w_sync, w_edge, w_wdata, w_set, w_clr;
  logic [WIDTH-1:0] r_irqmask, r_edgecap;
  logic [2:0]       r_arm_cnt;
  logic             w_armed, w_wr;
  logic [31:0]      w_rd_mux;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_in      (in_port),
    .o_sync    (w_sync),
    .o_edge    (w_edge)
  );

  if (WIDTH < 32) begin : g_wdata_hi
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[31:WIDTH];
  end

  assign w_wdata = writedata[WIDTH-1:0];
  assign w_wr    = chipselect && !write_n;
  assign w_armed = (r_arm_cnt == ARM_DONE);
  assign w_set   = w_armed ? w_edge : '0;
  assign w_clr   = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_arm_cnt <= '0;
    else if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irqmask <= '0;
    else if (w_wr && address == ADDR_IRQMASK) r_irqmask <= w_wdata;
  end

  // A new edge wins over a same-cycle write-1-to-clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_edgecap <= '0;
    else          r_edgecap <= w_set | (r_edgecap & ~w_clr);
  end

  always_comb begin
    w_rd_mux = '0;
    case (pio_addr_e'(address))
      ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_sync;
      ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rd_mux;
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_processador_pio_in.sv
module tb_processador_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [11:0] in_port, in_port_any;
  logic [31:0] readdata, readdata_any;
  logic        irq, irq_any;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Scoreboard: expected read values are pushed when the read is issued and
  // popped when readdata for that read becomes valid.
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  processador_pio_in #(.WIDTH(12), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  processador_pio_in #(.WIDTH(12), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port_any),
    .readdata   (readdata_any),
    .irq        (irq_any)
  );

  // All bus tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic exp_v, input bit any,
                          output logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    v = any ? readdata_any : readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v, e;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 12'hFFF; in_port_any = 12'h000;
    idle(3);
    n_total++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: readdata=%h irq=%b want 0/0", readdata, irq);
    end
    reset_n = 1'b1;
    idle(10);
    sb.push_back(32'hFFF); bus_read(2'd0, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL reset_data: got %h want %h", v, e); end
    sb.push_back(32'h0); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL reset_nospurious: got %h want %h", v, e); end
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_rising_irq;
    logic [31:0] v, e;
    logic exp_irq;
    in_port = 12'h000;
    idle(5);
    sb.push_back(32'h0); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL fall_ignored: got %h want %h", v, e); end
    bus_write(2'd2, 32'h001);
    in_port = 12'h001;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_irq = (c >= 3);
      n_total++;
      if (irq !== exp_irq) begin
        n_bad++;
        $display("FAIL rise_irq_cycle%0d: got %b want %b", c, irq, exp_irq);
      end
    end
    sb.push_back(32'h001); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL rise_cap: got %h want %h", v, e); end
    bus_write(2'd3, 32'h001);
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL clr_irq: got %b want 0", irq); end
    sb.push_back(32'h0); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL clr_cap: got %h want %h", v, e); end
  endtask

  task automatic test_mask;
    logic [31:0] v, e;
    bus_write(2'd2, 32'h000);
    in_port = 12'h089;
    idle(4);
    sb.push_back(32'h088); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL mask_cap: got %h want %h", v, e); end
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL mask_irq_off: got %b want 0", irq); end
    bus_write(2'd2, 32'h080);
    n_total++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL mask_irq_on: got %b want 1", irq); end
    sb.push_back(32'h080); bus_read(2'd2, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL mask_read: got %h want %h", v, e); end
    bus_write(2'd2, 32'h000);
    bus_write(2'd3, 32'hFFF);
  endtask

  task automatic test_collision;
    logic [31:0] v, e;
    in_port = 12'h08D;
    idle(4);
    sb.push_back(32'h004); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL coll_pre: got %h want %h", v, e); end
    in_port = 12'h089;
    idle(4);
    in_port = 12'h08D;
    idle(2);
    // Clear lands on the same edge that captures the new rising edge.
    bus_write(2'd3, 32'h004);
    sb.push_back(32'h004); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL coll_set_wins: got %h want %h", v, e); end
    bus_write(2'd3, 32'h004);
    sb.push_back(32'h0); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL coll_post_clr: got %h want %h", v, e); end
  endtask

  task automatic test_any_edge;
    logic [31:0] v, e;
    in_port_any = 12'h020;
    idle(4);
    sb.push_back(32'h020); bus_read(2'd3, 1'b1, 1'b1, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL any_rise: got %h want %h", v, e); end
    bus_write(2'd3, 32'h020);
    sb.push_back(32'h0); bus_read(2'd3, 1'b1, 1'b1, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL any_clr: got %h want %h", v, e); end
    in_port_any = 12'h000;
    idle(4);
    sb.push_back(32'h020); bus_read(2'd3, 1'b1, 1'b1, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL any_fall: got %h want %h", v, e); end
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    sb.push_back(32'h0); bus_read(2'd1, 1'b1, 1'b1, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL any_rsvd: got %h want %h", v, e); end
    sb.push_back(32'h0); bus_read(2'd0, 1'b1, 1'b1, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL any_data_ro: got %h want %h", v, e); end
    sb.push_back(32'h0); bus_read(2'd2, 1'b1, 1'b1, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL any_mask_kept: got %h want %h", v, e); end
    sb.push_back(32'h020); bus_read(2'd3, 1'b1, 1'b1, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL any_cap_kept: got %h want %h", v, e); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v, e;
    bus_write(2'd3, 32'hFFF);
    in_port = 12'h000;
    idle(4);
    bus_write(2'd3, 32'hFFF);
    bus_write(2'd2, 32'hFFF);
    in_port = 12'hABC;
    idle(4);
    sb.push_back(32'hABC); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL mid_cap: got %h want %h", v, e); end
    sb.push_back(32'hFFF); bus_read(2'd2, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL mid_mask: got %h want %h", v, e); end
    n_total++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL mid_irq_pre: got %b want 1", irq); end
    address = 2'd3; chipselect = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_async: readdata=%h irq=%b want 0/0", readdata, irq);
    end
    @(negedge clk);
    chipselect = 1'b0;
    reset_n = 1'b1;
    idle(10);
    sb.push_back(32'h0); bus_read(2'd3, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL post_cap: got %h want %h", v, e); end
    sb.push_back(32'h0); bus_read(2'd2, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL post_mask: got %h want %h", v, e); end
    sb.push_back(32'hABC); bus_read(2'd0, 1'b1, 1'b0, v); e = sb.pop_front();
    n_total++;
    if (v !== e) begin n_bad++; $display("FAIL post_data: got %h want %h", v, e); end
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL post_irq: got %b want 0", irq); end
  endtask

  initial begin
    test_reset;
    test_rising_irq;
    test_mask;
    test_collision;
    test_any_edge;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
